// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and fixed-point helpers.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;
  localparam int CNN_FRAC_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } relu_ctrl_state_t;

  // Converts a real constant into a signed fixed-point integer at elaboration time.
  function automatic int fx_const(input real value, input int frac_bits = CNN_FRAC_BITS);
    return int'(value * real'(32'd1 << frac_bits));
  endfunction

endpackage

// File: rtl/relu_stream_ctrl_relu.sv
// Combinational ReLU unit: passes strictly positive samples, zeroes the rest.
module relu_stream_ctrl_relu
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  // Zero and negative inputs (sign bit set) map to zero.
  always_comb begin
    if (enable && !in_data[DATA_WIDTH-1] && (in_data != {DATA_WIDTH{1'b0}})) begin
      out_data = in_data;
    end else begin
      out_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Frame-oriented ReLU stream controller with a 2-entry output FIFO.
// Optional ReLU6 clipping is enabled by defining RELU_CLIP6_EN.
module relu_stream_ctrl
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter  int FRAC_BITS  = CNN_FRAC_BITS,
  parameter  int FRAME_LEN  = 64,
  localparam int CNT_W      = $clog2(FRAME_LEN + 1),
  localparam int ELEM_W     = $clog2(FRAME_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic [CNT_W-1:0]             neg_cnt,
  output logic                         len_err,
  output logic                         done
);

  if (FRAME_LEN < 2 || FRAC_BITS >= DATA_WIDTH - 1) begin : g_param_check
    $error("relu_stream_ctrl: unsupported parameter combination");
  end

  logic signed [DATA_WIDTH-1:0] relu_out_s;
  logic signed [DATA_WIDTH-1:0] act_s;

  relu_stream_ctrl_relu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_relu (
    .enable  (1'b1),
    .in_data (s_data),
    .out_data(relu_out_s)
  );

`ifdef RELU_CLIP6_EN
  localparam logic signed [DATA_WIDTH-1:0] CLIP_CAP = DATA_WIDTH'(fx_const(6.0, FRAC_BITS));

  // Saturate the rectified sample at 6.0.
  always_comb begin
    if (relu_out_s > CLIP_CAP) begin
      act_s = CLIP_CAP;
    end else begin
      act_s = relu_out_s;
    end
  end
`else
  assign act_s = relu_out_s;
`endif

  relu_ctrl_state_t             state_q, state_d;
  logic [ELEM_W-1:0]            elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0]             neg_cnt_q, neg_cnt_d;
  logic                         len_err_q, len_err_d;
  logic                         done_q, done_d;
  logic                         s_ready_q, s_ready_d;
  logic                         m_valid_q, m_valid_d;
  logic signed [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                         m_last_q, m_last_d;
  logic signed [DATA_WIDTH-1:0] fifo_data_q [0:1];
  logic signed [DATA_WIDTH-1:0] fifo_data_d [0:1];
  logic                         fifo_last_q [0:1];
  logic                         fifo_last_d [0:1];
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic                         accept_s, pop_s, last_elem_s;

  // Next-state logic: handshakes, FIFO, frame counters and FSM.
  always_comb begin
    accept_s    = s_valid && s_ready_q;
    pop_s       = m_valid_q && m_ready;
    last_elem_s = (elem_cnt_q == ELEM_W'(FRAME_LEN - 1));

    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    neg_cnt_d   = neg_cnt_q;
    len_err_d   = len_err_q;
    done_d      = 1'b0;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;

    if (accept_s) begin
      fifo_data_d[wr_ptr_q] = act_s;
      fifo_last_d[wr_ptr_q] = last_elem_s;
      wr_ptr_d              = ~wr_ptr_q;
      if (last_elem_s) begin
        elem_cnt_d = {ELEM_W{1'b0}};
      end else begin
        elem_cnt_d = elem_cnt_q + ELEM_W'(1);
      end
      if (s_data[DATA_WIDTH-1] && (neg_cnt_q != CNT_W'(FRAME_LEN))) begin
        neg_cnt_d = neg_cnt_q + CNT_W'(1);
      end else begin
        neg_cnt_d = neg_cnt_q;
      end
      if (s_last != last_elem_s) begin
        len_err_d = 1'b1;
      end else begin
        len_err_d = len_err_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          elem_cnt_d = {ELEM_W{1'b0}};
          neg_cnt_d  = {CNT_W{1'b0}};
          len_err_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_elem_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // done fires on the edge that empties the FIFO, alongside the return to IDLE.
        if (count_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == RUN) && (count_d < 2'd2);
    m_valid_d = (count_d != 2'd0);
    if (count_d != 2'd0) begin
      m_data_d = fifo_data_d[rd_ptr_d];
      m_last_d = fifo_last_d[rd_ptr_d];
    end else begin
      m_data_d = m_data_q;
      m_last_d = m_last_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      elem_cnt_q     <= {ELEM_W{1'b0}};
      neg_cnt_q      <= {CNT_W{1'b0}};
      len_err_q      <= 1'b0;
      done_q         <= 1'b0;
      s_ready_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= {DATA_WIDTH{1'b0}};
      m_last_q       <= 1'b0;
      fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
      fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      state_q        <= state_d;
      elem_cnt_q     <= elem_cnt_d;
      neg_cnt_q      <= neg_cnt_d;
      len_err_q      <= len_err_d;
      done_q         <= done_d;
      s_ready_q      <= s_ready_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_last_q[0] <= fifo_last_d[0];
      fifo_last_q[1] <= fifo_last_d[1];
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign neg_cnt = neg_cnt_q;
  assign len_err = len_err_q;
  assign done    = done_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Bench for relu_stream_ctrl: queue-based reference model checked every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_relu_stream_ctrl;

  localparam int FL  = 4;
  localparam int DW  = 16;
  localparam int CW  = $clog2(FL + 1);
  localparam int CAP = 6 * 256;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, s_last, m_valid, m_ready, m_last, len_err, done;
  logic signed [DW-1:0] s_data, m_data;
  logic [CW-1:0] neg_cnt;

  relu_stream_ctrl #(.DATA_WIDTH(DW), .FRAC_BITS(8), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .neg_cnt(neg_cnt), .len_err(len_err), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_act(input int x);
    int y;
    y = (x > 0) ? x : 0;
`ifdef RELU_CLIP6_EN
    if (y > CAP) y = CAP;
`endif
    return y;
  endfunction

  // Reference model state: a frame is a sequence of FL accepts, results queue up to 2 deep.
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
  mode_t mode = M_IDLE;
  bit mdl_ok = 1'b0;
  int mq_d[$];
  bit mq_l[$];
  int n_in = 0, e_neg = 0, e_data = 0;
  bit e_len = 0, e_done = 0, e_s_ready = 0, e_last = 0;

  // Observation logs for directed checks.
  int cyc = 0, pop_cyc = 0, done_cyc = 0, done_cnt = 0;
  int beat_q[$];
  bit blast_q[$];

  always @(negedge clk) begin
    int x;
    bit acc, pop, want;
    cyc++;
    if (mdl_ok) begin
      chk("s_ready", s_ready, e_s_ready);
      chk("m_valid", m_valid, mq_d.size() != 0);
      chk("m_data", int'(m_data), e_data);
      if (mq_d.size() != 0) chk("m_last", m_last, e_last);
      chk("neg_cnt", neg_cnt, e_neg);
      chk("len_err", len_err, e_len);
      chk("done", done, e_done);
    end
    if (m_valid && m_ready) begin
      beat_q.push_back(int'(m_data));
      blast_q.push_back(m_last);
      pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    x = int'(s_data);
    if (rst) begin
      mq_d.delete(); mq_l.delete();
      mode = M_IDLE; n_in = 0; e_neg = 0; e_data = 0;
      e_len = 0; e_done = 0; e_s_ready = 0; e_last = 0; mdl_ok = 1'b1;
    end else if (mdl_ok) begin
      acc = s_valid && e_s_ready;
      pop = (mq_d.size() != 0) && m_ready;
      e_done = 0;
      if (pop) begin
        void'(mq_d.pop_front());
        void'(mq_l.pop_front());
      end
      if (acc) begin
        want = (n_in == FL - 1);
        mq_d.push_back(ref_act(x));
        mq_l.push_back(want);
        if (x < 0) e_neg++;
        if (s_last != want) e_len = 1;
        n_in++;
      end
      case (mode)
        M_IDLE:  if (start) begin mode = M_RUN; n_in = 0; e_neg = 0; e_len = 0; end
        M_RUN:   if (n_in == FL) mode = M_DRAIN;
        default: if (mq_d.size() == 0) begin mode = M_IDLE; e_done = 1; end
      endcase
      e_s_ready = (mode == M_RUN) && (mq_d.size() < 2);
      if (mq_d.size() != 0) begin
        e_data = mq_d[0];
        e_last = mq_l[0];
      end
    end
  end

  int fd[FL];
  bit fl[FL];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams fd/fl as one frame, then waits for done; start is optionally poked mid-frame.
  task automatic send_frame(input int vp, input int rp, input int stall_at, input int stall_len,
                            input bit poke);
    int idx = 0;
    int k = 0;
    bit did;
    while (idx < FL && k < 400) begin
      s_valid = ($urandom_range(99) < vp);
      s_data  = DW'(fd[idx]);
      s_last  = fl[idx];
      m_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : ($urandom_range(99) < rp);
      start   = poke && (k == 1);
      did     = s_valid && s_ready;
      tick();
      k++;
      if (did) idx++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    while (!done && k < 400) begin
      m_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : ($urandom_range(99) < rp);
      start   = poke && ($urandom_range(2) == 0);
      tick();
      k++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    tick();
    if (k >= 400) chk("frame_timeout", k, 0);
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3,
                      input bit l0, input bit l1, input bit l2, input bit l3);
    fd[0] = a0; fd[1] = a1; fd[2] = a2; fd[3] = a3;
    fl[0] = l0; fl[1] = l1; fl[2] = l2; fl[3] = l3;
    beat_q.delete();
    blast_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_neg_cnt", neg_cnt, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_done", done, 0);

    // Basic frame with free-flowing output.
    load(5, -3, 0, 7, 0, 0, 0, 1);
    d0 = done_cnt;
    do_start();
    send_frame(100, 100, 1000, 0, 1'b0);
    chk("t1_nbeats", beat_q.size(), 4);
    if (beat_q.size() == 4) begin
      chk("t1_b0", beat_q[0], 5);
      chk("t1_b1", beat_q[1], 0);
      chk("t1_b2", beat_q[2], 0);
      chk("t1_b3", beat_q[3], 7);
      chk("t1_lasts", {blast_q[0], blast_q[1], blast_q[2], blast_q[3]}, 4'b0001);
    end
    chk("t1_neg", neg_cnt, 1);
    chk("t1_len_err", len_err, 0);
    chk("t1_done_lat", done_cyc - pop_cyc, 1);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_m_valid_after", m_valid, 0);
    chk("t1_m_data_hold", int'(m_data), 7);

    // Output stall for 6 cycles mid-frame.
    load(100, -50, 200, 300, 0, 0, 0, 1);
    do_start();
    send_frame(100, 100, 1, 6, 1'b0);
    chk("t2_nbeats", beat_q.size(), 4);
    if (beat_q.size() == 4) begin
      chk("t2_b0", beat_q[0], 100);
      chk("t2_b1", beat_q[1], 0);
      chk("t2_b2", beat_q[2], 200);
      chk("t2_b3", beat_q[3], 300);
    end

    // Early s_last: sticky length error, frame still completes.
    load(1, 2, 3, 4, 0, 1, 0, 0);
    do_start();
    send_frame(100, 100, 1000, 0, 1'b0);
    chk("t3_len_err", len_err, 1);
    chk("t3_nbeats", beat_q.size(), 4);
    repeat (3) tick();
    chk("t3_len_err_sticky", len_err, 1);

    // start pokes during RUN and DRAIN are ignored; len_err cleared by this start.
    load(-1, -2, 9, -4, 0, 0, 0, 1);
    d0 = done_cnt;
    do_start();
    chk("t3_len_err_clear", len_err, 0);
    send_frame(100, 60, 2, 3, 1'b1);
    repeat (4) tick();
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_neg", neg_cnt, 3);
    chk("t5_nbeats", beat_q.size(), 4);

    // Reset with two entries buffered.
    do_start();
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'sd9; s_last = 1'b0;
    tick();
    s_data = -16'sd9;
    tick();
    s_valid = 1'b0;
    chk("t4_full_m_valid", m_valid, 1);
    chk("t4_full_s_ready", s_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_m_valid", m_valid, 0);
    chk("t4_s_ready", s_ready, 0);
    load(11, 0, -7, 13, 0, 0, 0, 1);
    do_start();
    send_frame(80, 80, 1000, 0, 1'b0);
    chk("t4_nbeats", beat_q.size(), 4);

`ifdef RELU_CLIP6_EN
    load(2000, 1536, -1, 10, 0, 0, 0, 1);
    do_start();
    send_frame(100, 100, 1000, 0, 1'b0);
    if (beat_q.size() == 4) begin
      chk("t6_b0", beat_q[0], 1536);
      chk("t6_b1", beat_q[1], 1536);
      chk("t6_b2", beat_q[2], 0);
      chk("t6_b3", beat_q[3], 10);
    end
    chk("t6_neg", neg_cnt, 1);
`endif

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < FL; i++) begin
        case ($urandom_range(3))
          0:       fd[i] = 0;
          1:       fd[i] = -int'($urandom_range(32768, 1));
          default: fd[i] = int'($urandom_range(32767, 1));
        endcase
        fl[i] = (i == FL - 1);
        if ($urandom_range(9) == 0) fl[i] = !fl[i];
      end
      s_valid = 1'b1;
      repeat ($urandom_range(3)) tick();
      s_valid = 1'b0;
      do_start();
      send_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                 int'($urandom_range(8)), int'($urandom_range(5)), f[0]);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
